// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types: register index, hazard sequencer states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hzd_state_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // Data-wait counter width bounds MAX_DWAIT to 2^16-1.
    localparam int unsigned WCNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module : pipeline_hazard_ctrl_if
// Brief  : Pipeline hazard controller signal bundle (hc / tb modports).
//          Counter signals exist only with PIPELINE_HAZARD_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if
`ifdef PIPELINE_HAZARD_PERF_CNT_EN
    #(parameter int unsigned PERF_W = 32)
`endif
    ;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     MEM_dREN;
    logic     MEM_dWEN;
    logic     MEM_halt;
    logic     EX_MemRead;
    regbits_t EX_wsel;
    regbits_t ID_rs;
    regbits_t ID_rt;
    logic     EX_branch_taken;
    logic     ID_jump;

    logic     pc_en;
    logic     IF_ID_en;
    logic     ID_EX_en;
    logic     EX_MEM_en;
    logic     MEM_WB_en;
    logic     IF_ID_flush;
    logic     ID_EX_flush;
    logic     imemREN;
    logic     halted;
    logic     dwait_timeout;

`ifdef PIPELINE_HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_cnt;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic [PERF_W-1:0] dwait_cnt;

    modport hc (
        input  ihit, dhit, MEM_dREN, MEM_dWEN, MEM_halt, EX_MemRead,
               EX_wsel, ID_rs, ID_rt, EX_branch_taken, ID_jump,
        output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, imemREN, halted, dwait_timeout,
               cyc_cnt, stall_cnt, flush_cnt, dwait_cnt
    );

    modport tb (
        output ihit, dhit, MEM_dREN, MEM_dWEN, MEM_halt, EX_MemRead,
               EX_wsel, ID_rs, ID_rt, EX_branch_taken, ID_jump,
        input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, imemREN, halted, dwait_timeout,
               cyc_cnt, stall_cnt, flush_cnt, dwait_cnt
    );
`else
    modport hc (
        input  ihit, dhit, MEM_dREN, MEM_dWEN, MEM_halt, EX_MemRead,
               EX_wsel, ID_rs, ID_rt, EX_branch_taken, ID_jump,
        output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, imemREN, halted, dwait_timeout
    );

    modport tb (
        output ihit, dhit, MEM_dREN, MEM_dWEN, MEM_halt, EX_MemRead,
               EX_wsel, ID_rs, ID_rt, EX_branch_taken, ID_jump,
        input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, imemREN, halted, dwait_timeout
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// ============================================================================
// Module : load_use_detect
// Brief  : Combinational load-use hazard compare between EX and ID stages.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_mem_read,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     stall
);

    // $0 is hard-wired, so a load targeting it never creates a dependency.
    assign stall = ex_mem_read
                && (ex_wsel != REG_ZERO)
                && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Stall/flush sequencer and shared memory-port arbiter for the
//          5-stage pipeline. Optional counters: PIPELINE_HAZARD_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DWAIT = 255
`ifdef PIPELINE_HAZARD_PERF_CNT_EN
    , parameter int unsigned PERF_W  = 32
`endif
) (
    input  logic                     CLK,
    input  logic                     RST,
    pipeline_hazard_ctrl_if.hc       hz
);

    localparam logic [WCNT_W-1:0] c_max_dwait = WCNT_W'(MAX_DWAIT);

    hzd_state_t        r_state;
    hzd_state_t        w_next_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_next;
    logic              r_halted;
    logic              r_timeout;

    logic w_dacc;
    logic w_load_use;
    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_fl, w_id_ex_fl, w_imem_ren;
    logic w_wait, w_wait_done, w_lu_apply, w_flush_apply;

    assign w_dacc = hz.MEM_dREN | hz.MEM_dWEN;

    load_use_detect u_load_use (
        .ex_mem_read (hz.EX_MemRead),
        .ex_wsel     (hz.EX_wsel),
        .id_rs       (hz.ID_rs),
        .id_rt       (hz.ID_rt),
        .stall       (w_load_use)
    );

    always_comb begin
        w_next_state  = r_state;
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_en    = 1'b0;
        w_ex_mem_en   = 1'b0;
        w_mem_wb_en   = 1'b0;
        w_if_id_fl    = 1'b0;
        w_id_ex_fl    = 1'b0;
        w_imem_ren    = 1'b0;
        w_wait        = 1'b0;
        w_wait_done   = 1'b0;
        w_lu_apply    = 1'b0;
        w_flush_apply = 1'b0;

        if (RST) begin
            w_next_state = RUN;
        end else if (r_state == HALT) begin
            w_next_state = HALT;
        end else if (hz.MEM_halt) begin
            // Let the halt instruction retire into WB, freeze everything else.
            w_mem_wb_en  = 1'b1;
            w_next_state = HALT;
        end else if (w_dacc && !hz.dhit) begin
            w_wait       = 1'b1;
            w_next_state = DWAIT;
        end else begin
            w_next_state = RUN;
            w_wait_done  = w_dacc;
            w_pc_en      = 1'b1;
            w_if_id_en   = 1'b1;
            w_id_ex_en   = 1'b1;
            w_ex_mem_en  = 1'b1;
            w_mem_wb_en  = 1'b1;
            // The data side owns the shared port while an access is in MEM.
            w_imem_ren   = !w_dacc;

            if (hz.EX_branch_taken) begin
                w_if_id_fl    = 1'b1;
                w_id_ex_fl    = 1'b1;
                w_flush_apply = 1'b1;
            end else if (w_load_use) begin
                w_pc_en    = 1'b0;
                w_if_id_en = 1'b0;
                w_id_ex_fl = 1'b1;
                w_lu_apply = 1'b1;
            end else if (hz.ID_jump) begin
                w_if_id_fl    = 1'b1;
                w_flush_apply = 1'b1;
            end else if (!w_dacc && !hz.ihit) begin
                w_pc_en    = 1'b0;
                w_if_id_fl = 1'b1;
            end
        end
    end

    assign w_wcnt_next = (r_wcnt == c_max_dwait) ? r_wcnt : r_wcnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= RUN;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= r_halted | (w_next_state == HALT);
            if (w_wait) begin
                r_wcnt <= w_wcnt_next;
                if (w_wcnt_next == c_max_dwait) begin
                    r_timeout <= 1'b1;
                end
            end else if (w_wait_done) begin
                r_wcnt <= '0;
            end
        end
    end

    // A flush is only meaningful when its latch actually loads.
    assign hz.pc_en         = w_pc_en;
    assign hz.IF_ID_en      = w_if_id_en;
    assign hz.ID_EX_en      = w_id_ex_en;
    assign hz.EX_MEM_en     = w_ex_mem_en;
    assign hz.MEM_WB_en     = w_mem_wb_en;
    assign hz.IF_ID_flush   = w_if_id_fl & w_if_id_en;
    assign hz.ID_EX_flush   = w_id_ex_fl & w_id_ex_en;
    assign hz.imemREN       = w_imem_ren;
    assign hz.halted        = r_halted;
    assign hz.dwait_timeout = r_timeout;

`ifdef PIPELINE_HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_cyc_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic [PERF_W-1:0] r_dwait_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_dwait_cnt <= '0;
        end else if (r_state != HALT) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_lu_apply)    r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_apply) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_wait)        r_dwait_cnt <= r_dwait_cnt + 1'b1;
        end
    end

    assign hz.cyc_cnt   = r_cyc_cnt;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
    assign hz.dwait_cnt = r_dwait_cnt;
`endif

endmodule

`default_nettype wire
